// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the FSM state encoding, the forwarding select codes and the register index width.
package hazard_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DMISS = 2'd2,
    ERR   = 2'd3
  } state_t;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_RF = 2'b00;
  localparam fwd_t FWD_W  = 2'b01;
  localparam fwd_t FWD_M  = 2'b10;

  // x0 is hardwired to zero, so a match on it must never forward.
  function automatic logic rd_hits(input logic we, input logic [REG_IDX_W-1:0] rd,
                                   input logic [REG_IDX_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// E-stage operand forwarding select for one source operand; pure combinational, 0 latency.
// No flow control: the result follows the register indices in the same cycle.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] Rs,
  input  logic [REG_IDX_W-1:0] RdM,
  input  logic [REG_IDX_W-1:0] RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  output logic [1:0]           Forward
);

  // M holds the younger result, so it takes priority over W.
  always_comb begin
    Forward = FWD_RF;
    if (rd_hits(RegWriteM, RdM, Rs))
      Forward = FWD_M;
    else if (rd_hits(RegWriteW, RdW, Rs))
      Forward = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage RV32I pipeline sequencer: stalls/flushes, forwarding, boot window, D-mem hang detect, perf counters.
// All controls are 0-latency functions of state and inputs; a D-mem wait freezes F..M and bubbles W.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES  = 4,
  parameter int unsigned DMEM_TIMEOUT = 256,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] Rs1E,
  input  logic [REG_IDX_W-1:0] Rs2E,
  input  logic [REG_IDX_W-1:0] RdE,
  input  logic [REG_IDX_W-1:0] RdM,
  input  logic [REG_IDX_W-1:0] RdW,
  input  logic                 ResultSrcE0,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 PCSrcE,
  input  logic                 JALRinstrE,
  input  logic                 imem_ready,
  input  logic                 dmem_req_M,
  input  logic                 dmem_ready,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 err_timeout,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned WW = $clog2(DMEM_TIMEOUT);

  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(DMEM_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [BW-1:0] boot_cnt, boot_cnt_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic          stall_inc, flush_inc;
  logic          lw, redir, dwait;

  fwd_sel u_fwd_a (
    .Rs        (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .Rs        (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Forward   (ForwardBE)
  );

  assign lw    = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign redir = PCSrcE | JALRinstrE;
  assign dwait = dmem_req_M && !dmem_ready;

  assign err_timeout = (state == ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      boot_cnt  <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall_inc)
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_inc)
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    wait_cnt_nxt = wait_cnt;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushW       = 1'b0;

    case (state)
      BOOT: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (boot_cnt == BOOT_LAST) begin
          state_nxt    = RUN;
          boot_cnt_nxt = '0;
        end else begin
          boot_cnt_nxt = boot_cnt + BW'(1);
        end
      end

      RUN, DMISS: begin
        // A stalled M stage freezes everything; any redirect is re-seen once it drains.
        if (dwait) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
        end else if (redir) begin
          FlushD    = 1'b1;
          FlushE    = 1'b1;
          flush_inc = 1'b1;
        end else if (lw) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (!imem_ready) begin
          StallF = 1'b1;
          FlushD = 1'b1;
        end
        stall_inc = StallF;

        if (state == RUN) begin
          if (dwait) begin
            state_nxt    = DMISS;
            wait_cnt_nxt = WW'(1);
          end
        end else if (!dwait) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WW'(1);
        end
      end

      ERR: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end

      default: state_nxt = BOOT;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, JALRinstrE;
  logic       imem_ready, dmem_req_M, dmem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       err_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_BOOT  = 7'b1100110;
  localparam logic [6:0] C_LOAD  = 7'b1100010;
  localparam logic [6:0] C_REDIR = 7'b0000110;
  localparam logic [6:0] C_IMISS = 7'b1000100;
  localparam logic [6:0] C_DWAIT = 7'b1111001;

  hazard_ctrl #(.BOOT_CYCLES(4), .DMEM_TIMEOUT(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .JALRinstrE(JALRinstrE),
    .imem_ready(imem_ready), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .err_timeout(err_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [6:0] exp);
    check(tag, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, exp});
  endtask

  // Commit one clock edge, then move 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; JALRinstrE = 0;
    imem_ready = 1; dmem_req_M = 0; dmem_ready = 0;
    #2;
    check_ctl("reset_ctl", C_BOOT);
    check("reset_fwd", {28'd0, ForwardAE, ForwardBE}, 32'd0);
    check("reset_err", {31'd0, err_timeout}, 32'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);

    // Boot window: exactly 4 cycles after release.
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2 check_ctl($sformatf("boot_%0d", i), C_BOOT);
      tick();
    end
    #2 check_ctl("run_idle", C_IDLE);
    check("boot_stall_cnt_frozen", stall_cnt, 32'd0);

    // Forwarding (combinational).
    RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
    #1 check("fwd_a_m_wins", {30'd0, ForwardAE}, 32'd2);
    check("fwd_b_m_wins", {30'd0, ForwardBE}, 32'd2);
    RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    #1 check("fwd_a_x0", {30'd0, ForwardAE}, 32'd0);
    RdM = 7; RdW = 9; Rs1E = 9; Rs2E = 7;
    #1 check("fwd_a_w_only", {30'd0, ForwardAE}, 32'd1);
    check("fwd_b_m_only", {30'd0, ForwardBE}, 32'd2);
    RegWriteM = 0; Rs2E = 7;
    #1 check("fwd_b_m_nowrite", {30'd0, ForwardBE}, 32'd0);
    RegWriteW = 0;
    #1 check("fwd_a_w_nowrite", {30'd0, ForwardAE}, 32'd0);

    // Load-use hazard.
    tick();
    ResultSrcE0 = 1; RdE = 3; Rs2D = 3;
    #2 check_ctl("load_use", C_LOAD);
    tick();
    check("load_stall_cnt", stall_cnt, 32'd1);
    RdE = 0; Rs2D = 0;
    #2 check_ctl("load_rd_x0", C_IDLE);
    RdE = 3; Rs2D = 3; PCSrcE = 1;
    #2 check_ctl("load_with_branch", C_REDIR);
    tick();
    check("branch_flush_cnt", flush_cnt, 32'd1);
    check("branch_stall_cnt", stall_cnt, 32'd1);
    ResultSrcE0 = 0; RdE = 0; Rs2D = 0; PCSrcE = 0;

    // Fetch miss, with and without JALR.
    imem_ready = 0; JALRinstrE = 1;
    #2 check_ctl("imiss_jalr", C_REDIR);
    tick();
    check("jalr_flush_cnt", flush_cnt, 32'd2);
    JALRinstrE = 0;
    #2 check_ctl("imiss", C_IMISS);
    tick();
    check("imiss_stall_cnt", stall_cnt, 32'd2);
    imem_ready = 1;

    // D-mem wait for 3 cycles with a pending branch that must be ignored.
    dmem_req_M = 1; dmem_ready = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #2 check_ctl($sformatf("dwait_%0d", i), C_DWAIT);
      tick();
    end
    check("dwait_flush_cnt", flush_cnt, 32'd2);
    dmem_ready = 1;
    #2 check_ctl("dmem_done_redir", C_REDIR);
    tick();
    check("dwait_stall_cnt", stall_cnt, 32'd5);
    check("redir_after_dwait_cnt", flush_cnt, 32'd3);
    dmem_req_M = 0; PCSrcE = 0;
    #2 check_ctl("back_to_run", C_IDLE);
    tick();

    // Hung D-mem: 8 wait cycles, then ERR.
    dmem_req_M = 1; dmem_ready = 0;
    for (int i = 0; i < 8; i++) begin
      #2 check_ctl($sformatf("hang_%0d", i), C_DWAIT);
      check($sformatf("hang_err_%0d", i), {31'd0, err_timeout}, 32'd0);
      tick();
    end
    #2 check("err_set", {31'd0, err_timeout}, 32'd1);
    check_ctl("err_ctl", C_DWAIT);
    check("err_stall_cnt", stall_cnt, 32'd13);
    dmem_req_M = 0; dmem_ready = 1;
    tick(); tick();
    check("err_sticky", {31'd0, err_timeout}, 32'd1);
    check_ctl("err_ctl_sticky", C_DWAIT);
    check("err_stall_cnt_frozen", stall_cnt, 32'd13);
    check("err_flush_cnt_frozen", flush_cnt, 32'd3);

    // Asynchronous reset out of ERR.
    #2 reset = 1'b1;
    #1 check("rst_err_clear", {31'd0, err_timeout}, 32'd0);
    check_ctl("rst_ctl", C_BOOT);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2 check_ctl($sformatf("reboot_%0d", i), C_BOOT);
      tick();
    end
    #2 check_ctl("rerun_idle", C_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
